// File: rtl/obi_ram_arbiter.sv
// Shares one single-port RAM between OBI fetch and data masters; grants are combinational and the RAM never stalls.
// Each response returns to its own master RAM_LATENCY cycles after its grant, in grant order; a loser holds its request.
module obi_ram_arbiter #(
   parameter int unsigned RAM_ADDR_WIDTH = 18,
   parameter int unsigned RAM_LATENCY    = 1,
   parameter int unsigned ARB_MODE       = 0
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      instr_req_i,
   input  logic [31:0]               instr_addr_i,
   output logic                      instr_gnt_o,
   output logic                      instr_rvalid_o,
   output logic [31:0]               instr_rdata_o,
   input  logic                      data_req_i,
   input  logic [31:0]               data_addr_i,
   input  logic                      data_we_i,
   input  logic [3:0]                data_be_i,
   input  logic [31:0]               data_wdata_i,
   output logic                      data_gnt_o,
   output logic                      data_rvalid_o,
   output logic [31:0]               data_rdata_o,
   output logic                      ram_en_o,
   output logic                      ram_we_o,
   output logic [3:0]                ram_be_o,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
   output logic [31:0]               ram_wdata_o,
   input  logic [31:0]               ram_rdata_i,
   output logic [31:0]               conflict_cnt_o
);
   localparam int unsigned LAST = RAM_LATENCY - 1;

   typedef enum logic {OWNER_INSTR = 1'b0, OWNER_DATA = 1'b1} owner_e;

   if (RAM_LATENCY < 1 || RAM_LATENCY > 2) begin : g_bad_latency
      $fatal(1, "obi_ram_arbiter: RAM_LATENCY must be 1 or 2");
   end

   // Address bits above the RAM window are intentionally dropped.
   if (RAM_ADDR_WIDTH < 32) begin : g_addr_trunc
      logic unused_addr_hi;
      assign unused_addr_hi = ^{instr_addr_i[31:RAM_ADDR_WIDTH], data_addr_i[31:RAM_ADDR_WIDTH]};
   end

   owner_e                 last_winner_q, last_winner_d;
   logic [RAM_LATENCY-1:0] vld_q, vld_d;
   logic [RAM_LATENCY-1:0] own_q, own_d;
   logic [RAM_LATENCY-1:0] we_q, we_d;
   logic [31:0]            cnt_q, cnt_d;
   logic                   both_req, data_win, instr_gnt, data_gnt;
   logic                   resp_instr, resp_data, resp_rd;

   always_comb begin : arbitrate
      both_req = instr_req_i & data_req_i;
      if (ARB_MODE == 1) begin
         data_win = data_req_i;
      end else begin
         data_win = data_req_i & (~instr_req_i | (last_winner_q == OWNER_INSTR));
      end
      data_gnt  = ~rst_i & data_win;
      instr_gnt = ~rst_i & instr_req_i & ~data_win;
   end

   assign instr_gnt_o    = instr_gnt;
   assign data_gnt_o     = data_gnt;
   assign conflict_cnt_o = cnt_q;

   always_comb begin : ram_drive
      ram_en_o    = instr_gnt | data_gnt;
      ram_we_o    = 1'b0;
      ram_be_o    = '0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      if (data_gnt) begin
         ram_we_o    = data_we_i;
         ram_be_o    = data_be_i;
         ram_addr_o  = data_addr_i[RAM_ADDR_WIDTH-1:0];
         ram_wdata_o = data_wdata_i;
      end else if (instr_gnt) begin
         ram_be_o   = 4'hF;
         ram_addr_o = instr_addr_i[RAM_ADDR_WIDTH-1:0];
      end
   end

   always_comb begin : next_state
      vld_d    = vld_q;
      own_d    = own_q;
      we_d     = we_q;
      vld_d[0] = instr_gnt | data_gnt;
      own_d[0] = data_gnt;
      we_d[0]  = data_gnt & data_we_i;
      for (int i = 1; i < int'(RAM_LATENCY); i++) begin
         vld_d[i] = vld_q[i-1];
         own_d[i] = own_q[i-1];
         we_d[i]  = we_q[i-1];
      end
      // Round-robin memory only moves on contested cycles.
      last_winner_d = last_winner_q;
      if (both_req) begin
         last_winner_d = data_win ? OWNER_DATA : OWNER_INSTR;
      end
      cnt_d = cnt_q;
      if (both_req && cnt_q != 32'hFFFF_FFFF) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_q         <= '0;
         own_q         <= '0;
         we_q          <= '0;
         last_winner_q <= OWNER_INSTR;
         cnt_q         <= '0;
      end else begin
         vld_q         <= vld_d;
         own_q         <= own_d;
         we_q          <= we_d;
         last_winner_q <= last_winner_d;
         cnt_q         <= cnt_d;
      end
   end

   always_comb begin : respond
      resp_instr     = ~rst_i & vld_q[LAST] & ~own_q[LAST];
      resp_data      = ~rst_i & vld_q[LAST] & own_q[LAST];
      resp_rd        = ~we_q[LAST];
      instr_rvalid_o = resp_instr;
      data_rvalid_o  = resp_data;
      instr_rdata_o  = '0;
      data_rdata_o   = '0;
      if (resp_instr & resp_rd) begin
         instr_rdata_o = ram_rdata_i;
      end
      if (resp_data & resp_rd) begin
         data_rdata_o = ram_rdata_i;
      end
   end
endmodule

// File: tb/tb_obi_ram_arbiter.sv
// Drives three arbiter configurations (RR/lat1, fixed-priority/lat1, RR/lat2) with shared stimulus
// and checks each against a cycle-level reference model and a shadow copy of its RAM.
module tb_obi_ram_arbiter;
   localparam int N     = 3;
   localparam int AW    = 18;
   localparam int MEMW  = 4096;
   localparam int SLOTS = 256;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, mem_init;
   logic        instr_req, data_req, data_we;
   logic [31:0] instr_addr, data_addr, data_wdata;
   logic [3:0]  data_be;

   logic          instr_gnt    [N];
   logic          instr_rvalid [N];
   logic [31:0]   instr_rdata  [N];
   logic          data_gnt     [N];
   logic          data_rvalid  [N];
   logic [31:0]   data_rdata   [N];
   logic          ram_en       [N];
   logic          ram_we       [N];
   logic [3:0]    ram_be       [N];
   logic [AW-1:0] ram_addr     [N];
   logic [31:0]   ram_wdata    [N];
   logic [31:0]   ram_rdata    [N];
   logic [31:0]   conflict_cnt [N];

   function automatic int mode_of(int k);
      return (k == 1) ? 1 : 0;
   endfunction

   function automatic int lat_of(int k);
      return (k == 2) ? 2 : 1;
   endfunction

   function automatic logic [31:0] init_word(int i);
      if (i == 'h060) return 32'h0000_0013;
      if (i == 'h400) return 32'h1122_3344;
      return 32'hC0DE_0000 ^ 32'(i);
   endfunction

   for (genvar g = 0; g < N; g++) begin : g_dut
      logic [31:0] mem [MEMW];
      logic [31:0] rd0_q, rd1_q;

      obi_ram_arbiter #(
         .RAM_ADDR_WIDTH(AW),
         .RAM_LATENCY   ((g == 2) ? 2 : 1),
         .ARB_MODE      ((g == 1) ? 1 : 0)
      ) u_dut (
         .clk_i         (clk),
         .rst_i         (rst),
         .instr_req_i   (instr_req),
         .instr_addr_i  (instr_addr),
         .instr_gnt_o   (instr_gnt[g]),
         .instr_rvalid_o(instr_rvalid[g]),
         .instr_rdata_o (instr_rdata[g]),
         .data_req_i    (data_req),
         .data_addr_i   (data_addr),
         .data_we_i     (data_we),
         .data_be_i     (data_be),
         .data_wdata_i  (data_wdata),
         .data_gnt_o    (data_gnt[g]),
         .data_rvalid_o (data_rvalid[g]),
         .data_rdata_o  (data_rdata[g]),
         .ram_en_o      (ram_en[g]),
         .ram_we_o      (ram_we[g]),
         .ram_be_o      (ram_be[g]),
         .ram_addr_o    (ram_addr[g]),
         .ram_wdata_o   (ram_wdata[g]),
         .ram_rdata_i   (ram_rdata[g]),
         .conflict_cnt_o(conflict_cnt[g])
      );

      // Behavioural single-port RAM: one-cycle read, optional extra output register.
      always @(posedge clk) begin
         if (mem_init) begin
            for (int i = 0; i < MEMW; i++) mem[i] <= init_word(i);
         end else begin
            if (ram_en[g] && !ram_we[g]) rd0_q <= mem[ram_addr[g][13:2]];
            if (ram_en[g] && ram_we[g]) begin
               for (int b = 0; b < 4; b++)
                  if (ram_be[g][b]) mem[ram_addr[g][13:2]][8*b +: 8] <= ram_wdata[g][8*b +: 8];
            end
         end
         rd1_q <= rd0_q;
      end
      assign ram_rdata[g] = (g == 2) ? rd1_q : rd0_q;
   end

   // Reference model state
   logic [31:0] sh     [N][MEMW];
   bit          last_d [N];
   longint      m_cnt  [N];
   bit          s_vld  [N][SLOTS];
   bit          s_dat  [N][SLOTS];
   bit          s_rd   [N][SLOTS];
   logic [31:0] s_rdat [N][SLOTS];
   int          cyc;
   int          n_checks, n_errors;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
      end
   endtask

   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da,
                        input logic dwe, input logic [3:0] dbe, input logic [31:0] dwd, input logic r);
      instr_req  = ir;
      instr_addr = ia;
      data_req   = dr;
      data_addr  = da;
      data_we    = dwe;
      data_be    = dbe;
      data_wdata = dwd;
      rst        = r;
   endtask

   task automatic idle(input logic r);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, r);
   endtask

   task automatic model_cycle(input int k);
      bit          both, eig, edg, dwin, erv, is_rd;
      int          slot, a, due;
      logic [31:0] addr, erdat;
      both = instr_req && data_req;
      slot = cyc % SLOTS;
      eig  = 1'b0;
      edg  = 1'b0;
      dwin = 1'b0;
      if (!rst) begin
         if (both) begin
            dwin = (mode_of(k) == 1) || !last_d[k];
            edg  = dwin;
            eig  = !dwin;
         end else begin
            edg = data_req;
            eig = instr_req;
         end
      end
      check($sformatf("instr_gnt[%0d]", k), instr_gnt[k], eig);
      check($sformatf("data_gnt[%0d]", k), data_gnt[k], edg);
      check($sformatf("ram_en[%0d]", k), ram_en[k], eig | edg);
      check($sformatf("ram_we[%0d]", k), ram_we[k], edg && data_we);
      check($sformatf("ram_be[%0d]", k), ram_be[k], eig ? 4'hF : (edg ? data_be : 4'h0));
      check($sformatf("ram_wdata[%0d]", k), ram_wdata[k], edg ? data_wdata : 32'h0);
      addr = edg ? data_addr : instr_addr;
      if (eig || edg) check($sformatf("ram_addr[%0d]", k), ram_addr[k], addr % (32'd1 << AW));
      erv   = !rst && s_vld[k][slot];
      erdat = (erv && s_rd[k][slot]) ? s_rdat[k][slot] : 32'h0;
      check($sformatf("instr_rvalid[%0d]", k), instr_rvalid[k], erv && !s_dat[k][slot]);
      check($sformatf("data_rvalid[%0d]", k), data_rvalid[k], erv && s_dat[k][slot]);
      check($sformatf("instr_rdata[%0d]", k), instr_rdata[k], (erv && !s_dat[k][slot]) ? erdat : 32'h0);
      check($sformatf("data_rdata[%0d]", k), data_rdata[k], (erv && s_dat[k][slot]) ? erdat : 32'h0);
      check($sformatf("conflict_cnt[%0d]", k), conflict_cnt[k], m_cnt[k]);
      s_vld[k][slot] = 1'b0;
      if (rst) begin
         for (int i = 0; i < SLOTS; i++) s_vld[k][i] = 1'b0;
         last_d[k] = 1'b0;
         m_cnt[k]  = 0;
      end else begin
         if (both) begin
            last_d[k] = dwin;
            if (m_cnt[k] < 64'hFFFF_FFFF) m_cnt[k]++;
         end
         if (eig || edg) begin
            a     = int'(((addr % (32'd1 << AW)) / 4) % MEMW);
            due   = (cyc + lat_of(k)) % SLOTS;
            is_rd = !(edg && data_we);
            s_vld[k][due]  = 1'b1;
            s_dat[k][due]  = edg;
            s_rd[k][due]   = is_rd;
            s_rdat[k][due] = sh[k][a];
            if (!is_rd) begin
               for (int b = 0; b < 4; b++)
                  if (data_be[b]) sh[k][a][8*b +: 8] = data_wdata[8*b +: 8];
            end
         end
      end
   endtask

   task automatic step();
      #3;
      for (int k = 0; k < N; k++) model_cycle(k);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      cyc      = 0;
      for (int k = 0; k < N; k++) begin
         last_d[k] = 1'b0;
         m_cnt[k]  = 0;
         for (int i = 0; i < SLOTS; i++) s_vld[k][i] = 1'b0;
         for (int i = 0; i < MEMW; i++) sh[k][i] = init_word(i);
      end
      mem_init = 1'b1;
      idle(1'b1);
      @(posedge clk);
      #1;
      mem_init = 1'b0;

      // Reset forces everything quiet even with both requests up.
      drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 4'hF, 32'h1, 1'b1);
      step();

      // Lone fetch.
      drive(1'b1, 32'h180, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
      #1;
      check("fetch_gnt", instr_gnt[0], 1'b1);
      check("fetch_addr", ram_addr[0], 18'h180);
      check("fetch_be", ram_be[0], 4'hF);
      step();
      check("fetch_rvalid", instr_rvalid[0], 1'b1);
      check("fetch_rdata", instr_rdata[0], 32'h0000_0013);
      check("fetch_no_drv", data_rvalid[0], 1'b0);

      // Partial write then read-back.
      drive(1'b0, 32'h0, 1'b1, 32'h1000, 1'b1, 4'h3, 32'hDEAD_BEEF, 1'b0);
      #1;
      check("wr_be", ram_be[0], 4'h3);
      step();
      check("wr_rvalid", data_rvalid[0], 1'b1);
      check("wr_rdata", data_rdata[0], 32'h0);
      drive(1'b0, 32'h0, 1'b1, 32'h1000, 1'b0, 4'hF, 32'h0, 1'b0);
      step();
      check("rd_rvalid", data_rvalid[0], 1'b1);
      check("rd_rdata", data_rdata[0], 32'h1122_BEEF);
      idle(1'b0);
      step();
      step();

      // Six contested cycles after reset.
      idle(1'b1);
      step();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 32'h200 + 32'(4 * i), 1'b1, 32'h300 + 32'(4 * i), 1'b0, 4'hF, 32'h0, 1'b0);
         #1;
         check("rr_dgnt", data_gnt[0], (i % 2) == 0);
         check("rr_ignt", instr_gnt[0], (i % 2) == 1);
         check("fp_dgnt", data_gnt[1], 1'b1);
         check("fp_ignt", instr_gnt[1], 1'b0);
         step();
      end
      for (int k = 0; k < N; k++) check($sformatf("conf6[%0d]", k), conflict_cnt[k], 32'd6);
      drive(1'b1, 32'h220, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
      #1;
      check("fp_instr_after", instr_gnt[1], 1'b1);
      step();

      // Address beyond the RAM window wraps.
      drive(1'b1, 32'h0004_0010, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
      #1;
      check("addr_wrap", ram_addr[0], 18'h00010);
      step();
      idle(1'b0);
      step();

      // Reset while a latency-2 response is in flight.
      drive(1'b1, 32'h180, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
      step();
      idle(1'b1);
      #1;
      check("rst_l2_rvalid", instr_rvalid[2], 1'b0);
      check("rst_l2_en", ram_en[2], 1'b0);
      step();
      idle(1'b0);
      for (int i = 0; i < 2; i++) begin
         #1;
         check("post_rst_l2_rvalid", instr_rvalid[2], 1'b0);
         check("post_rst_cnt", conflict_cnt[2], 32'd0);
         step();
      end

      // Random traffic with occasional reset.
      for (int i = 0; i < 500; i++) begin
         drive(1'($urandom_range(0, 1)),
               ($urandom & 32'hFFFC_0000) | 32'($urandom_range(0, 63) * 4),
               1'($urandom_range(0, 1)),
               ($urandom & 32'hFFFC_0000) | 32'($urandom_range(0, 63) * 4),
               1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)),
               $urandom,
               $urandom_range(0, 49) == 0);
         step();
      end
      idle(1'b0);
      for (int i = 0; i < 4; i++) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
